// File: rtl/mccontroller.sv
// mccontroller: multicycle control sequencer for the MIPS core.
// Walks each instruction through fetch, decode, execute, memory and
// writeback, time-sharing one ALU and one unified memory port. Memory steps
// wait on memready, so a variable-latency memory stalls the sequence.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | read instruction at PC, PC+4 into PC when memory completes
// DECODE | dispatch on op, compute branch target into ALUOut
// MEMADR | compute load/store address rs + signext(imm)
// MEMRD  | read data memory at ALUOut until memready
// MEMWB  | write loaded data to rt
// MEMWR  | write register B to memory at ALUOut until memready
// REX    | R-type ALU operation selected by funct
// RWB    | write ALUOut to rd
// BEQ    | compare rs/rt, take branch target from ALUOut when zero
// IEX    | immediate ALU operation (addi/andi/ori/lui)
// IWB    | write ALUOut to rt
// JMP    | load jump target into PC

module mccontroller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       memready_i,
    output logic       pcen_o,
    output logic       iord_o,
    output logic       memread_o,
    output logic       memwrite_o,
    output logic       irwrite_o,
    output logic       regdst_o,
    output logic       memtoreg_o,
    output logic       regwrite_o,
    output logic       alusrca_o,
    output logic [1:0] alusrcb_o,
    output logic [1:0] pcsrc_o,
    output logic [1:0] immtype_o,
    output logic [2:0] alucontrol_o,
    output logic       illegal_o,
    output logic       instr_done_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_IEX    = 4'd9,
        S_IWB    = 4'd10,
        S_JMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALUOUT  = 2'b01;
    localparam logic [1:0] PC_JUMP    = 2'b10;

    localparam logic [1:0] IMM_SIGN   = 2'b00;
    localparam logic [1:0] IMM_ZERO   = 2'b01;
    localparam logic [1:0] IMM_SETHI  = 2'b10;

    state_t state_q;
    state_t state_d;

    // State register; reset parks the sequencer in FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode. The op/funct fields come from the
    // instruction register, which only changes in FETCH, so decoding them in
    // later states is stable for the whole instruction.
    always_comb begin
        state_d      = state_q;
        pcen_o       = 1'b0;
        iord_o       = 1'b0;
        memread_o    = 1'b0;
        memwrite_o   = 1'b0;
        irwrite_o    = 1'b0;
        regdst_o     = 1'b0;
        memtoreg_o   = 1'b0;
        regwrite_o   = 1'b0;
        alusrca_o    = 1'b0;
        alusrcb_o    = SRCB_REGB;
        pcsrc_o      = 2'b00;
        immtype_o    = IMM_SIGN;
        alucontrol_o = ALU_ADD;
        illegal_o    = 1'b0;
        instr_done_o = 1'b0;

        case (state_q)
            S_FETCH: begin
                iord_o    = 1'b0;
                memread_o = 1'b1;
                alusrca_o = 1'b0;
                alusrcb_o = SRCB_FOUR;
                if (memready_i) begin
                    irwrite_o = 1'b1;
                    pcen_o    = 1'b1;
                    state_d   = S_DECODE;
                end
            end

            S_DECODE: begin
                alusrca_o = 1'b0;
                alusrcb_o = SRCB_IMMSH;
                immtype_o = IMM_SIGN;
                case (op_i)
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_RTYPE:                         state_d = S_REX;
                    OP_BEQ:                           state_d = S_BEQ;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_IEX;
                    OP_J:                             state_d = S_JMP;
                    default: begin
                        illegal_o    = 1'b1;
                        instr_done_o = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                alusrca_o = 1'b1;
                alusrcb_o = SRCB_IMM;
                immtype_o = IMM_SIGN;
                state_d   = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            end

            S_MEMRD: begin
                iord_o    = 1'b1;
                memread_o = 1'b1;
                if (memready_i) begin
                    state_d = S_MEMWB;
                end
            end

            S_MEMWB: begin
                regdst_o     = 1'b0;
                memtoreg_o   = 1'b1;
                regwrite_o   = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end

            S_MEMWR: begin
                iord_o     = 1'b1;
                memwrite_o = 1'b1;
                if (memready_i) begin
                    instr_done_o = 1'b1;
                    state_d      = S_FETCH;
                end
            end

            S_REX: begin
                alusrca_o = 1'b1;
                alusrcb_o = SRCB_REGB;
                state_d   = S_RWB;
                case (funct_i)
                    FN_ADD: alucontrol_o = ALU_ADD;
                    FN_SUB: alucontrol_o = ALU_SUB;
                    FN_AND: alucontrol_o = ALU_AND;
                    FN_OR:  alucontrol_o = ALU_OR;
                    FN_SLT: alucontrol_o = ALU_SLT;
                    default: begin
                        illegal_o    = 1'b1;
                        instr_done_o = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end

            S_RWB: begin
                regdst_o     = 1'b1;
                memtoreg_o   = 1'b0;
                regwrite_o   = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end

            S_BEQ: begin
                alusrca_o    = 1'b1;
                alusrcb_o    = SRCB_REGB;
                alucontrol_o = ALU_SUB;
                pcsrc_o      = PC_ALUOUT;
                pcen_o       = zero_i;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end

            S_IEX: begin
                alusrca_o = 1'b1;
                alusrcb_o = SRCB_IMM;
                state_d   = S_IWB;
                case (op_i)
                    OP_ANDI: begin
                        immtype_o    = IMM_ZERO;
                        alucontrol_o = ALU_AND;
                    end
                    OP_ORI: begin
                        immtype_o    = IMM_ZERO;
                        alucontrol_o = ALU_OR;
                    end
                    // lui relies on rs being $0, so OR passes the shifted immediate
                    OP_LUI: begin
                        immtype_o    = IMM_SETHI;
                        alucontrol_o = ALU_OR;
                    end
                    default: begin
                        immtype_o    = IMM_SIGN;
                        alucontrol_o = ALU_ADD;
                    end
                endcase
            end

            S_IWB: begin
                regdst_o     = 1'b0;
                memtoreg_o   = 1'b0;
                regwrite_o   = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end

            S_JMP: begin
                pcsrc_o      = PC_JUMP;
                pcen_o       = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset must silence every strobe at once, including the FETCH read
        // request that the reset state would otherwise drive.
        if (reset) begin
            pcen_o       = 1'b0;
            iord_o       = 1'b0;
            memread_o    = 1'b0;
            memwrite_o   = 1'b0;
            irwrite_o    = 1'b0;
            regdst_o     = 1'b0;
            memtoreg_o   = 1'b0;
            regwrite_o   = 1'b0;
            alusrca_o    = 1'b0;
            alusrcb_o    = 2'b00;
            pcsrc_o      = 2'b00;
            immtype_o    = 2'b00;
            alucontrol_o = 3'b000;
            illegal_o    = 1'b0;
            instr_done_o = 1'b0;
            state_d      = S_FETCH;
        end
    end

endmodule

// File: tb/tb_mccontroller.sv
// Directed bench for mccontroller: walks each instruction class cycle by
// cycle and compares the full control word against hand-derived values.

module tb_mccontroller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       pcen, iord, memread, memwrite, irwrite, regdst, memtoreg;
    logic       regwrite, alusrca, illegal, instr_done;
    logic [1:0] alusrcb, pcsrc, immtype;
    logic [2:0] alucontrol;

    int checks   = 0;
    int failures = 0;

    mccontroller dut (
        .clk          (clk),
        .reset        (reset),
        .op_i         (op),
        .funct_i      (funct),
        .zero_i       (zero),
        .memready_i   (memready),
        .pcen_o       (pcen),
        .iord_o       (iord),
        .memread_o    (memread),
        .memwrite_o   (memwrite),
        .irwrite_o    (irwrite),
        .regdst_o     (regdst),
        .memtoreg_o   (memtoreg),
        .regwrite_o   (regwrite),
        .alusrca_o    (alusrca),
        .alusrcb_o    (alusrcb),
        .pcsrc_o      (pcsrc),
        .immtype_o    (immtype),
        .alucontrol_o (alucontrol),
        .illegal_o    (illegal),
        .instr_done_o (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flag bits: pcen iord memread memwrite irwrite regdst memtoreg regwrite alusrca illegal instr_done
    localparam logic [10:0] PCEN = 11'b10000000000;
    localparam logic [10:0] IORD = 11'b01000000000;
    localparam logic [10:0] MRD  = 11'b00100000000;
    localparam logic [10:0] MWR  = 11'b00010000000;
    localparam logic [10:0] IRW  = 11'b00001000000;
    localparam logic [10:0] RDST = 11'b00000100000;
    localparam logic [10:0] M2R  = 11'b00000010000;
    localparam logic [10:0] RW   = 11'b00000001000;
    localparam logic [10:0] ASA  = 11'b00000000100;
    localparam logic [10:0] ILL  = 11'b00000000010;
    localparam logic [10:0] DONE = 11'b00000000001;

    function automatic logic [19:0] cw(input logic [10:0] f, input logic [1:0] sb,
                                       input logic [1:0] ps, input logic [1:0] it,
                                       input logic [2:0] ac);
        return {f[10:2], sb, ps, it, ac, f[1], f[0]};
    endfunction

    function automatic logic [19:0] observed();
        return {pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
                alusrca, alusrcb, pcsrc, immtype, alucontrol, illegal, instr_done};
    endfunction

    task automatic chk(input string tag, input logic [19:0] exp);
        logic [19:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive memready/zero for the current cycle, check, advance to next cycle.
    task automatic step(input string tag, input logic mr, input logic z, input logic [19:0] exp);
        memready = mr;
        zero     = z;
        #1;
        chk(tag, exp);
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset    = 1'b1;
        op       = 6'b100011;
        funct    = 6'b000000;
        zero     = 1'b0;
        memready = 1'b1;

        #3;
        chk("reset_outputs_zero", 20'd0);
        @(posedge clk);
        #2;
        chk("reset_held_after_edge", 20'd0);
        reset = 1'b0;

        // lw, memready high: 5 cycles
        op = 6'b100011;
        step("lw_fetch",  1'b1, 1'b0, cw(PCEN|MRD|IRW, 2'b01, 2'b00, 2'b00, 3'b010));
        step("lw_decode", 1'b1, 1'b0, cw(11'd0,        2'b11, 2'b00, 2'b00, 3'b010));
        step("lw_memadr", 1'b1, 1'b0, cw(ASA,          2'b10, 2'b00, 2'b00, 3'b010));
        step("lw_memrd",  1'b1, 1'b0, cw(IORD|MRD,     2'b00, 2'b00, 2'b00, 3'b010));
        step("lw_memwb",  1'b1, 1'b0, cw(M2R|RW|DONE,  2'b00, 2'b00, 2'b00, 3'b010));

        // sw with memready low 3 cycles in MEMWR
        op = 6'b101011;
        step("sw_fetch",   1'b1, 1'b0, cw(PCEN|MRD|IRW,   2'b01, 2'b00, 2'b00, 3'b010));
        step("sw_decode",  1'b1, 1'b0, cw(11'd0,          2'b11, 2'b00, 2'b00, 3'b010));
        step("sw_memadr",  1'b1, 1'b0, cw(ASA,            2'b10, 2'b00, 2'b00, 3'b010));
        step("sw_wait1",   1'b0, 1'b0, cw(IORD|MWR,       2'b00, 2'b00, 2'b00, 3'b010));
        step("sw_wait2",   1'b0, 1'b0, cw(IORD|MWR,       2'b00, 2'b00, 2'b00, 3'b010));
        step("sw_wait3",   1'b0, 1'b0, cw(IORD|MWR,       2'b00, 2'b00, 2'b00, 3'b010));
        step("sw_done",    1'b1, 1'b0, cw(IORD|MWR|DONE,  2'b00, 2'b00, 2'b00, 3'b010));

        // R-type slt, with one fetch stall cycle
        op = 6'b000000;
        funct = 6'b101010;
        step("slt_fetch_stall", 1'b0, 1'b0, cw(MRD,           2'b01, 2'b00, 2'b00, 3'b010));
        step("slt_fetch",       1'b1, 1'b0, cw(PCEN|MRD|IRW,  2'b01, 2'b00, 2'b00, 3'b010));
        step("slt_decode",      1'b1, 1'b0, cw(11'd0,         2'b11, 2'b00, 2'b00, 3'b010));
        step("slt_rex",         1'b1, 1'b0, cw(ASA,           2'b00, 2'b00, 2'b00, 3'b111));
        step("slt_rwb",         1'b1, 1'b0, cw(RDST|RW|DONE,  2'b00, 2'b00, 2'b00, 3'b010));

        // R-type sub
        funct = 6'b100010;
        step("sub_fetch",  1'b1, 1'b0, cw(PCEN|MRD|IRW, 2'b01, 2'b00, 2'b00, 3'b010));
        step("sub_decode", 1'b1, 1'b0, cw(11'd0,        2'b11, 2'b00, 2'b00, 3'b010));
        step("sub_rex",    1'b1, 1'b0, cw(ASA,          2'b00, 2'b00, 2'b00, 3'b110));
        step("sub_rwb",    1'b1, 1'b0, cw(RDST|RW|DONE, 2'b00, 2'b00, 2'b00, 3'b010));

        // R-type illegal funct
        funct = 6'b000111;
        step("badfn_fetch",  1'b1, 1'b0, cw(PCEN|MRD|IRW, 2'b01, 2'b00, 2'b00, 3'b010));
        step("badfn_decode", 1'b1, 1'b0, cw(11'd0,        2'b11, 2'b00, 2'b00, 3'b010));
        step("badfn_rex",    1'b1, 1'b0, cw(ASA|ILL|DONE, 2'b00, 2'b00, 2'b00, 3'b010));

        // beq taken
        op = 6'b000100;
        step("beqt_fetch",  1'b1, 1'b0, cw(PCEN|MRD|IRW,  2'b01, 2'b00, 2'b00, 3'b010));
        step("beqt_decode", 1'b1, 1'b0, cw(11'd0,         2'b11, 2'b00, 2'b00, 3'b010));
        step("beqt_beq",    1'b1, 1'b1, cw(PCEN|ASA|DONE, 2'b00, 2'b01, 2'b00, 3'b110));

        // beq not taken
        step("beqn_fetch",  1'b1, 1'b0, cw(PCEN|MRD|IRW, 2'b01, 2'b00, 2'b00, 3'b010));
        step("beqn_decode", 1'b1, 1'b0, cw(11'd0,        2'b11, 2'b00, 2'b00, 3'b010));
        step("beqn_beq",    1'b1, 1'b0, cw(ASA|DONE,     2'b00, 2'b01, 2'b00, 3'b110));

        // lui
        op = 6'b001111;
        step("lui_fetch",  1'b1, 1'b0, cw(PCEN|MRD|IRW, 2'b01, 2'b00, 2'b00, 3'b010));
        step("lui_decode", 1'b1, 1'b0, cw(11'd0,        2'b11, 2'b00, 2'b00, 3'b010));
        step("lui_iex",    1'b1, 1'b0, cw(ASA,          2'b10, 2'b00, 2'b10, 3'b001));
        step("lui_iwb",    1'b1, 1'b0, cw(RW|DONE,      2'b00, 2'b00, 2'b00, 3'b010));

        // andi
        op = 6'b001100;
        step("andi_fetch",  1'b1, 1'b0, cw(PCEN|MRD|IRW, 2'b01, 2'b00, 2'b00, 3'b010));
        step("andi_decode", 1'b1, 1'b0, cw(11'd0,        2'b11, 2'b00, 2'b00, 3'b010));
        step("andi_iex",    1'b1, 1'b0, cw(ASA,          2'b10, 2'b00, 2'b01, 3'b000));
        step("andi_iwb",    1'b1, 1'b0, cw(RW|DONE,      2'b00, 2'b00, 2'b00, 3'b010));

        // addi
        op = 6'b001000;
        step("addi_fetch",  1'b1, 1'b0, cw(PCEN|MRD|IRW, 2'b01, 2'b00, 2'b00, 3'b010));
        step("addi_decode", 1'b1, 1'b0, cw(11'd0,        2'b11, 2'b00, 2'b00, 3'b010));
        step("addi_iex",    1'b1, 1'b0, cw(ASA,          2'b10, 2'b00, 2'b00, 3'b010));
        step("addi_iwb",    1'b1, 1'b0, cw(RW|DONE,      2'b00, 2'b00, 2'b00, 3'b010));

        // j
        op = 6'b000010;
        step("j_fetch",  1'b1, 1'b0, cw(PCEN|MRD|IRW, 2'b01, 2'b00, 2'b00, 3'b010));
        step("j_decode", 1'b1, 1'b0, cw(11'd0,        2'b11, 2'b00, 2'b00, 3'b010));
        step("j_jmp",    1'b1, 1'b0, cw(PCEN|DONE,    2'b00, 2'b10, 2'b00, 3'b010));

        // illegal op
        op = 6'b111111;
        step("badop_fetch",  1'b1, 1'b0, cw(PCEN|MRD|IRW, 2'b01, 2'b00, 2'b00, 3'b010));
        step("badop_decode", 1'b1, 1'b0, cw(ILL|DONE,     2'b11, 2'b00, 2'b00, 3'b010));

        // lw interrupted by reset in MEMRD
        op = 6'b100011;
        step("rst_lw_fetch",  1'b1, 1'b0, cw(PCEN|MRD|IRW, 2'b01, 2'b00, 2'b00, 3'b010));
        step("rst_lw_decode", 1'b1, 1'b0, cw(11'd0,        2'b11, 2'b00, 2'b00, 3'b010));
        step("rst_lw_memadr", 1'b1, 1'b0, cw(ASA,          2'b10, 2'b00, 2'b00, 3'b010));
        memready = 1'b0;
        #1;
        chk("rst_lw_memrd_wait", cw(IORD|MRD, 2'b00, 2'b00, 2'b00, 3'b010));
        reset = 1'b1;
        #1;
        chk("rst_midinstr_zero", 20'd0);
        @(posedge clk);
        #2;
        chk("rst_midinstr_held", 20'd0);
        reset = 1'b0;
        #1;
        chk("rst_release_fetch_stall", cw(MRD, 2'b01, 2'b00, 2'b00, 3'b010));
        memready = 1'b1;
        #1;
        chk("rst_release_fetch", cw(PCEN|MRD|IRW, 2'b01, 2'b00, 2'b00, 3'b010));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
